// File: rtl/id_stage_hazard_ctrl_if.sv
// Decode-stage control bundle: ID/EX hazard inputs and front-end pipeline enables.
// The slave modport is the sequencer's view; master is the pipeline's view.
interface id_stage_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_is_div;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_redirect;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
    logic             div_start;
    logic             busy;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_div,
        input  ex_mem_read, ex_rd, ex_redirect,
        output pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, div_start, busy
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_div,
        output ex_mem_read, ex_rd, ex_redirect,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, div_start, busy
    );
endinterface

// File: rtl/id_stage_hazard_ctrl.sv
// Stall/flush sequencer at the IF/ID -> ID/EX boundary: load-use stalls, redirect
// squashes and front-end freeze while a fixed-latency divider occupies EX.
module id_stage_hazard_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int REG_W       = 5
) (
    input logic                       clk,
    input logic                       rst,
    id_stage_hazard_ctrl_if.slave     ctrl
);
    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_W-1:0] rs1, rs2, exRd;
    logic             hz;
    logic             pcWe, ifidWe, ifidFlush, idexBubble, exHold, divStart, busyOut;

    assign rs1  = ctrl.id_rs1;
    assign rs2  = ctrl.id_rs2;
    assign exRd = ctrl.ex_rd;

    // Load-use: a load in EX writes a register that the instruction in ID reads.
    assign hz = ctrl.id_valid & ctrl.ex_mem_read & (exRd != '0) &
                ((ctrl.id_uses_rs1 & (rs1 == exRd)) | (ctrl.id_uses_rs2 & (rs2 == exRd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcWe       = 1'b0;
        ifidWe     = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        exHold     = 1'b0;
        divStart   = 1'b0;
        busyOut    = 1'b0;

        case (state_q)
            DIV_BUSY: begin
                // EX holds the divide, so redirects and load-use cannot arise here.
                exHold  = 1'b1;
                busyOut = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (ctrl.ex_redirect) begin
                    pcWe       = 1'b1;
                    ifidWe     = 1'b1;
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                end else if (hz) begin
                    idexBubble = 1'b1;
                end else if (ctrl.id_valid && ctrl.id_is_div) begin
                    divStart = 1'b1;
                    pcWe     = 1'b1;
                    ifidWe   = 1'b1;
                    state_d  = DIV_BUSY;
                    cnt_d    = CNT_W'(DIV_LATENCY);
                end else begin
                    pcWe   = 1'b1;
                    ifidWe = 1'b1;
                end
            end
        endcase

        // Reset forces a NOP into both pipeline registers and freezes the PC.
        if (rst) begin
            pcWe       = 1'b0;
            ifidWe     = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            exHold     = 1'b0;
            divStart   = 1'b0;
            busyOut    = 1'b0;
        end
    end

    assign ctrl.pc_we       = pcWe;
    assign ctrl.ifid_we     = ifidWe;
    assign ctrl.ifid_flush  = ifidFlush;
    assign ctrl.idex_bubble = idexBubble;
    assign ctrl.ex_hold     = exHold;
    assign ctrl.div_start   = divStart;
    assign ctrl.busy        = busyOut;
endmodule

// File: tb/tb_id_stage_hazard_ctrl.sv
// Scoreboard bench for id_stage_hazard_ctrl: directed corner cases then random traffic,
// with expected outputs from a cycle-level model queued and checked by a separate monitor.
module tb_id_stage_hazard_ctrl;
    localparam int LAT   = 4;
    localparam int REG_W = 5;

    logic clk;
    logic rst;

    id_stage_hazard_ctrl_if #(.REG_W(REG_W)) busIf ();

    id_stage_hazard_ctrl #(.DIV_LATENCY(LAT), .REG_W(REG_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (busIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector: {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, div_start, busy}
    logic [6:0] expQ[$];
    int         cycleQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    int         divLeft = 0;

    function automatic logic [6:0] modelStep(
        input logic r, input logic v, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
        input logic u1, input logic u2, input logic dv, input logic mr,
        input logic [REG_W-1:0] rd, input logic redir);
        logic readsRd;
        if (r) begin
            divLeft = 0;
            return 7'b0011000;
        end
        if (divLeft > 0) begin
            divLeft = divLeft - 1;
            return 7'b0000101;
        end
        readsRd = (u1 && s1 == rd) || (u2 && s2 == rd);
        if (redir) return 7'b1111000;
        if (v && mr && rd != 0 && readsRd) return 7'b0001000;
        if (v && dv) begin
            divLeft = LAT;
            return 7'b1100010;
        end
        return 7'b1100000;
    endfunction

    task automatic applyStimulus(
        input logic r, input logic v, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
        input logic u1, input logic u2, input logic dv, input logic mr,
        input logic [REG_W-1:0] rd, input logic redir);
        rst                     = r;
        busIf.id_valid          = v;
        busIf.id_rs1            = s1;
        busIf.id_rs2            = s2;
        busIf.id_uses_rs1       = u1;
        busIf.id_uses_rs2       = u2;
        busIf.id_is_div         = dv;
        busIf.ex_mem_read       = mr;
        busIf.ex_rd             = rd;
        busIf.ex_redirect       = redir;
        expQ.push_back(modelStep(r, v, s1, s2, u1, u2, dv, mr, rd, redir));
        cycleQ.push_back(cycle);
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input logic [6:0] exp, input int cyc);
        logic [6:0] got;
        got = {busIf.pc_we, busIf.ifid_we, busIf.ifid_flush, busIf.idex_bubble,
               busIf.ex_hold, busIf.div_start, busIf.busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL outputs cycle %0d: got pc/ifid/flush/bubble/hold/start/busy=%b expected %b",
                     cyc, got, exp);
        end
    endtask

    // Monitor: the outputs are valid every cycle, so each falling edge retires one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front(), cycleQ.pop_front());
        end
    end

    initial begin
        logic [REG_W-1:0] pool [6];
        pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2;
        pool[3] = 5'd5; pool[4] = 5'd7; pool[5] = 5'd31;

        rst = 1'b1;
        busIf.id_valid = 0; busIf.id_rs1 = 0; busIf.id_rs2 = 0; busIf.id_uses_rs1 = 0;
        busIf.id_uses_rs2 = 0; busIf.id_is_div = 0; busIf.ex_mem_read = 0; busIf.ex_rd = 0;
        busIf.ex_redirect = 0;
        @(posedge clk);
        #1;

        // reset held, then released with idle inputs
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs1, then load gone
        applyStimulus(0, 1, 5, 3, 1, 0, 0, 1, 5, 0);
        applyStimulus(0, 1, 5, 3, 1, 0, 0, 0, 5, 0);
        // x0 destination and unused rs2 operand
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 7, 1, 0, 0, 1, 7, 0);
        // load-use on rs2
        applyStimulus(0, 1, 1, 7, 0, 1, 0, 1, 7, 0);
        // divide; redirect and hazard during busy must be ignored
        applyStimulus(0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 5, 5, 1, 1, 0, 1, 5, 1);
        applyStimulus(0, 1, 5, 5, 1, 1, 0, 1, 5, 0);
        applyStimulus(0, 1, 2, 3, 1, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        // back-to-back divide starts in the first RUN cycle
        applyStimulus(0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < LAT; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // redirect beats hazard and divide
        applyStimulus(0, 1, 5, 0, 1, 0, 1, 1, 5, 1);
        // reset mid-divide
        applyStimulus(0, 1, 2, 3, 1, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 7) != 0),
                          pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom),
                          pool[$urandom_range(0, 5)],
                          ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
